// File: rtl/lenet_pkg.sv
// Shared constants for the LeNet-5 layer pipeline.
// State encodings, layer indices and datapath width.
package lenet_pkg;

  localparam int DATA_WIDTH = 12;

  localparam int L_FRONT = 0;
  localparam int L_MID   = 1;
  localparam int L_FC1   = 2;
  localparam int L_FC2   = 3;

  localparam int I_IDLE = 0;
  localparam int I_RUN  = 1;
  localparam int I_REL  = 2;
  localparam int I_FIN  = 3;
  localparam int I_ERR  = 4;

  localparam logic [4:0] S_IDLE = 5'b00001;
  localparam logic [4:0] S_RUN  = 5'b00010;
  localparam logic [4:0] S_REL  = 5'b00100;
  localparam logic [4:0] S_FIN  = 5'b01000;
  localparam logic [4:0] S_ERR  = 5'b10000;

endpackage

// File: rtl/lenet_watchdog.sv
// Per-layer watchdog: counts enabled cycles and flags
// expiry when the count reaches the limit.
module lenet_watchdog #(
  parameter int TO_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_i,
  input  logic                en_i,
  input  logic [TO_WIDTH-1:0] limit_i,
  output logic                expire_o
);

  logic [TO_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == limit_i);

endmodule

// File: rtl/lenet_layer_sequencer.sv
// Runs the LeNet layers in order via en/done handshakes,
// muxes the shared weight ROM address and guards each layer.
module lenet_layer_sequencer
  import lenet_pkg::*;
#(
  parameter int NUM_LAYERS     = 4,
  parameter int W_ADDR_WIDTH   = 10,
  parameter int TO_WIDTH       = 16,
  parameter int TIMEOUT_CYCLES = 60000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               abort,
  input  logic [NUM_LAYERS-1:0]              layer_done,
  input  logic [NUM_LAYERS*W_ADDR_WIDTH-1:0] layer_w_addr,
  output logic [NUM_LAYERS-1:0]              layer_en,
  output logic [W_ADDR_WIDTH-1:0]            w_rom_addr,
  output logic [2:0]                         cur_layer,
  output logic                               busy,
  output logic                               done,
  output logic                               error
);

  logic [4:0]              state_q, state_d;
  logic [NUM_LAYERS-1:0]   en_q, en_d;
  logic [2:0]              cur_q, cur_d;
  logic [W_ADDR_WIDTH-1:0] addr_q, addr_sel;
  logic                    err_q, err_d;
  logic                    rel_cnt_q, rel_cnt_d;
  logic                    busy_q, done_q;
  logic                    cur_done, wd_exp, wd_clr, last;

  always_comb begin
    cur_done = 1'b0;
    addr_sel = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (cur_q == 3'(i)) begin
        cur_done = layer_done[i];
        addr_sel = layer_w_addr[i*W_ADDR_WIDTH +: W_ADDR_WIDTH];
      end
    end
  end

  assign last   = (cur_q == 3'(NUM_LAYERS - 1));
  assign wd_clr = !state_q[I_RUN] || abort || cur_done;

  lenet_watchdog #(
    .TO_WIDTH (TO_WIDTH)
  ) u_wd (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (wd_clr),
    .en_i     (state_q[I_RUN]),
    .limit_i  (TO_WIDTH'(TIMEOUT_CYCLES - 1)),
    .expire_o (wd_exp)
  );

  // abort wins over layer_done, which wins over expiry
  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    cur_d     = cur_q;
    err_d     = err_q;
    rel_cnt_d = 1'b0;
    if (abort && !state_q[I_IDLE]) begin
      state_d = S_IDLE;
      en_d    = '0;
      cur_d   = 3'(L_FRONT);
    end else begin
      unique case (1'b1)
        state_q[I_IDLE]: begin
          if (start) begin
            state_d = S_RUN;
            cur_d   = 3'(L_FRONT);
            err_d   = 1'b0;
            en_d    = NUM_LAYERS'(1);
          end
        end
        state_q[I_RUN]: begin
          if (cur_done) begin
            state_d = S_REL;
            en_d    = '0;
          end else if (wd_exp) begin
            state_d = S_ERR;
            en_d    = '0;
            err_d   = 1'b1;
          end
        end
        state_q[I_REL]: begin
          if (!rel_cnt_q) begin
            rel_cnt_d = 1'b1;
          end else if (last) begin
            state_d = S_FIN;
          end else begin
            state_d = S_RUN;
            cur_d   = cur_q + 3'd1;
            en_d    = NUM_LAYERS'(1) << (cur_q + 3'd1);
          end
        end
        state_q[I_FIN]: begin
          state_d = S_IDLE;
          cur_d   = 3'(L_FRONT);
        end
        state_q[I_ERR]: begin
          en_d = '0;
        end
        default: begin
          state_d = S_IDLE;
          en_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      en_q      <= '0;
      cur_q     <= '0;
      addr_q    <= '0;
      err_q     <= 1'b0;
      rel_cnt_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      cur_q     <= cur_d;
      err_q     <= err_d;
      rel_cnt_q <= rel_cnt_d;
      busy_q    <= !state_d[I_IDLE];
      done_q    <= state_d[I_FIN];
      if (!state_q[I_IDLE] && !state_q[I_ERR]) begin
        addr_q <= addr_sel;
      end
    end
  end

  assign layer_en   = en_q;
  assign w_rom_addr = addr_q;
  assign cur_layer  = cur_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = err_q;

endmodule

// File: tb/tb_lenet_layer_sequencer.sv
// Directed and randomized checks of the layer sequencer
// against a cycle-schedule model of the layer pipeline.
module tb_lenet_layer_sequencer;

  localparam int NL = 4;
  localparam int AW = 10;
  localparam int TW = 16;
  localparam int TO = 20;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic [NL-1:0]    layer_done;
  logic [NL*AW-1:0] layer_w_addr;
  logic [NL-1:0]    layer_en;
  logic [AW-1:0]    w_rom_addr;
  logic [2:0]       cur_layer;
  logic             busy;
  logic             done;
  logic             error;

  int            n_vec = 0;
  int            n_bad = 0;
  logic [AW-1:0] exp_addr;

  always #5 clk = ~clk;

  lenet_layer_sequencer #(
    .NUM_LAYERS     (NL),
    .W_ADDR_WIDTH   (AW),
    .TO_WIDTH       (TW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .layer_done   (layer_done),
    .layer_w_addr (layer_w_addr),
    .layer_en     (layer_en),
    .w_rom_addr   (w_rom_addr),
    .cur_layer    (cur_layer),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] slice(input logic [NL*AW-1:0] v,
                                          input int i);
    return v[i*AW +: AW];
  endfunction

  function automatic logic [NL*AW-1:0] gen_addr(input bit fixed);
    logic [NL*AW-1:0] v;
    logic [AW-1:0]    f [NL];
    f = '{10'h011, 10'h122, 10'h233, 10'h344};
    for (int i = 0; i < NL; i++) begin
      v[i*AW +: AW] = fixed ? f[i] : AW'($urandom);
    end
    return v;
  endfunction

  // Layer i asserts done lat[i] cycles after its enable rises and
  // holds it until it has seen en low; cycle 1 is the first after start.
  task automatic run(input string nm, input int lat[NL], input int hang,
                     input int abort_c, input int rst_c, input bit spur,
                     input bit fixed);
    int               s [NL+1];
    int               err_c, last, ecur;
    logic [NL-1:0]    een, dn;
    logic             ebusy, edone, eerr, in_err, post_a, post_r;
    logic [NL*AW-1:0] a;
    s[0] = 1;
    for (int i = 0; i < NL; i++) s[i+1] = s[i] + lat[i] + 3;
    err_c = (hang >= 0) ? s[hang] + TO : 32'h7fffffff;
    last  = s[NL] + 3;
    if (abort_c > 0) last = abort_c + 3;
    if (rst_c > 0) last = rst_c + 3;
    a = gen_addr(fixed);
    layer_w_addr = a;
    start = 1'b1;
    abort = 1'b0;
    rst = 1'b0;
    layer_done = '0;
    @(posedge clk); #1;
    for (int c = 1; c <= last; c++) begin
      post_a = abort_c > 0 && c > abort_c;
      post_r = rst_c > 0 && c > rst_c;
      een = '0; ecur = 0; ebusy = 0; edone = 0; eerr = 0; in_err = 0;
      if (post_r) begin
        eerr = 1'b0;
      end else if (post_a) begin
        eerr = (err_c <= abort_c);
      end else if (c >= err_c) begin
        ecur = hang; ebusy = 1; eerr = 1; in_err = 1;
      end else begin
        for (int i = 0; i < NL; i++) begin
          if (c >= s[i] && c <= s[i] + lat[i]) een[i] = 1'b1;
          if (c >= s[i]) ecur = i;
        end
        ebusy = (c <= s[NL]);
        edone = (c == s[NL]);
      end
      chk({nm, ".en"}, 32'(layer_en), 32'(een));
      chk({nm, ".busy"}, 32'(busy), 32'(ebusy));
      chk({nm, ".done"}, 32'(done), 32'(edone));
      chk({nm, ".error"}, 32'(error), 32'(eerr));
      chk({nm, ".addr"}, 32'(w_rom_addr), 32'(exp_addr));
      if (ebusy || post_a || post_r)
        chk({nm, ".cur"}, 32'(cur_layer), 32'(ecur));
      dn = '0;
      if (!post_a && !post_r) begin
        for (int i = 0; i < NL; i++) begin
          if (i != hang && c >= s[i] + lat[i] && c <= s[i] + lat[i] + 1)
            dn[i] = 1'b1;
        end
      end
      if (spur && c < s[1]) dn[NL-1] = 1'b1;
      a = fixed ? a : gen_addr(1'b0);
      layer_w_addr = a;
      layer_done = dn;
      start = spur && (c == 3);
      abort = (c == abort_c);
      rst = (c == rst_c);
      if (c == rst_c) exp_addr = '0;
      else if (ebusy && !in_err) exp_addr = slice(a, ecur);
      @(posedge clk); #1;
    end
    start = 1'b0;
    abort = 1'b0;
    rst = 1'b0;
    layer_done = '0;
  endtask

  initial begin
    int l [NL];
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    layer_done = '0;
    layer_w_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset.en", 32'(layer_en), 32'd0);
    chk("reset.cur", 32'(cur_layer), 32'd0);
    chk("reset.addr", 32'(w_rom_addr), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk("reset.error", 32'(error), 32'd0);
    exp_addr = '0;
    @(posedge clk); #1;

    run("normal", '{10, 11, 12, 13}, -1, 0, 0, 1'b0, 1'b1);
    run("spurious", '{10, 11, 12, 13}, -1, 0, 0, 1'b1, 1'b0);
    // layer 1 hangs: s1=14, ERR from 34, abort during 39
    run("watchdog", '{10, TO + 5, 10, 10}, 1, 39, 0, 1'b0, 1'b0);
    run("after_err", '{10, 11, 12, 13}, -1, 0, 0, 1'b0, 1'b1);
    // abort on the same edge as layer 2 done: s2=28, done at 40
    run("abort", '{10, 11, 12, 13}, -1, 40, 0, 1'b0, 1'b0);
    run("rst_mid", '{10, 11, 12, 13}, -1, 0, 18, 1'b0, 1'b0);
    run("fresh", '{10, 11, 12, 13}, -1, 0, 0, 1'b0, 1'b1);
    // done coincides with watchdog expiry: done must win
    run("edge_to", '{TO - 1, 3, TO - 1, 1}, -1, 0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      foreach (l[i]) l[i] = int'($urandom_range(1, TO - 1));
      run("random", l, -1, 0, 0, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lenet_layer_sequencer.md
Name: lenet_layer_sequencer

Overview:
Top-level scheduler for the LeNet-5 layer pipeline. It runs the layer blocks (front conv+pool, mid conv+pool, FC stages) one after another through their en/done handshake. Each layer's enable is held until that layer reports done, then dropped so the layer FSM returns to IDLE. The block also shares the single weight ROM address port among the layers and guards every layer with a watchdog timeout.

Parameters:
NUM_LAYERS, 4, number of sequenced layers (index 0 runs first)
W_ADDR_WIDTH, 10, weight ROM address width
TO_WIDTH, 16, watchdog counter width
TIMEOUT_CYCLES, 60000, maximum cycles allowed in RUN per layer (must be < 2^TO_WIDTH)

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
start  input  1  request to run the full network; sampled only in IDLE
abort  input  1  cancel the current run; sampled in any non-IDLE state
layer_done  input  NUM_LAYERS  per-layer done level (high while that layer sits in its DONE state)
layer_w_addr  input  NUM_LAYERS*W_ADDR_WIDTH  per-layer weight address requests; slice i belongs to layer i
layer_en  output  NUM_LAYERS  one-hot layer enable, registered
w_rom_addr  output  W_ADDR_WIDTH  registered mux of layer_w_addr selected by cur_layer
cur_layer  output  3  index of the active layer
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when the last layer has finished and been released
error  output  1  sticky watchdog flag

Behaviour:
- Reset: state=IDLE, layer_en=0, cur_layer=0, w_rom_addr=0, busy=0, done=0, error=0, watchdog=0, rel_cnt=0.
- States use one-hot encoding: IDLE, RUN, RELEASE, FIN, ERR.
- IDLE: if start is sampled high at edge k:
  - next state RUN, cur_layer=0, error cleared.
  - layer_en=1<<0 and busy=1 are visible from cycle k+1.
- RUN:
  - layer_en=1<<cur_layer; watchdog increments every cycle.
  - If layer_done[cur_layer] is sampled high at edge m: state RELEASE and layer_en=0 from m+1; watchdog cleared.
  - layer_done bits of non-current layers are ignored.
- RELEASE: lasts exactly 2 cycles with layer_en=0, giving the layer FSM time to see en low and return to IDLE.
  - If cur_layer<NUM_LAYERS-1: cur_layer increments and state returns to RUN, so the next enable rises at m+3.
  - Otherwise: state FIN.
- FIN: done=1 for exactly one cycle, then IDLE. busy falls on the same edge that leaves FIN.
- Watchdog: if the counter reaches TIMEOUT_CYCLES-1 while still in RUN, go to ERR.
  - ERR: layer_en=0, error=1 (sticky), busy=1.
  - ERR exits to IDLE only on abort or rst; error stays high in IDLE until the next accepted start or rst.
- abort in RUN, RELEASE, FIN or ERR: state IDLE and layer_en=0 on the next cycle; cur_layer=0; no done pulse.
- abort takes priority over layer_done and watchdog expiry on the same edge. layer_done takes priority over watchdog expiry.
- start while busy is ignored. abort in IDLE is ignored.
- w_rom_addr: registered every cycle from slice cur_layer of layer_w_addr, so latency is 1 cycle. It holds its value in IDLE and ERR.
- rst mid-operation: every output returns to its reset value on the next edge; the downstream layer sees en low.

Decomposition:
- Package lenet_pkg holds:
  - state one-hot localparams (IDLE/RUN/RELEASE/FIN/ERR);
  - layer index constants (L_FRONT=0, L_MID=1, L_FC1=2, L_FC2=3);
  - the shared DATA_WIDTH=12.
- One sub-module is natural: lenet_watchdog (clear, enable and count inputs, expire output).
- The address mux stays inline.

Test Plan:
- Normal run: pulse start; layer i asserts done 10+i cycles after its enable rises. Required response:
  - enables appear in order 1,2,4,8, each separated by exactly 2 low cycles;
  - done pulses once;
  - busy falls with no error.
- Watchdog with TIMEOUT_CYCLES=20: layer 1 never asserts done. Required response: layer_en goes to 0 and error=1 after 20 cycles in RUN; the state stays ERR until abort, then returns to IDLE.
- Abort during layer 2 RUN, issued on the same edge as layer_done[2]. Required response: IDLE next cycle, layer_en=0, no done pulse, cur_layer=0.
- Start while busy plus spurious done: a second start pulse during layer 0, and layer_done[3] held high during layer 0. Required response: both are ignored; layer 0 stays enabled until layer_done[0].
- Address mux: drive slices 0x011/0x122/0x233/0x344. Required response: w_rom_addr tracks the slice for cur_layer with 1-cycle latency across every layer switch.
- Reset mid-run in layer 1. Required response: all outputs at reset values on the next cycle; a fresh start then runs from layer 0.
